rf_wb_arbiter: RTL and testbench

- Write-side front end for the 32x32 MIPS register file. Merges two result sources onto the file's single write port (wr/addr3/data3):
  - the in-order pipeline writeback (port A);
  - the long-latency unit (mul/div, uncached loads) results (port B).
- Buffers B results in a small FIFO.
- Keeps a per-register pending scoreboard, which decode uses to stall on outstanding long-latency destinations.

---
 rtl/rf_wb_arbiter_pkg.sv | 22 ++
 rtl/rf_wb_arbiter_wb_fifo.sv | 73 +++++++
 rtl/rf_wb_arbiter.sv | 157 +++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
//   REG_ZERO / NUM_REGS / DATA_W : register file geometry
//   wb_entry_t                   : buffered long-latency result {addr, data}
//   wb_src_e                     : which source drives the write port on a given edge
package rf_wb_arbiter_pkg;

    localparam logic [4:0]  REG_ZERO = 5'd0;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned DATA_W   = 32;

    typedef struct packed {
        logic [4:0]        addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_A,
        SRC_B
    } wb_src_e;

endpackage

// File: rtl/rf_wb_arbiter_wb_fifo.sv
// Synchronous FIFO holding long-latency results until the write port is free.
//   clk, reset     : clock, synchronous active-high reset (empties the FIFO)
//   push_i/entry_i : enqueue request and data (ignored when full unless popping)
//   pop_i          : dequeue request (ignored when empty)
//   head_o         : oldest entry, valid when !empty_o
//   count_o        : registered occupancy
//   full_o/empty_o : occupancy flags
module rf_wb_arbiter_wb_fifo
    import rf_wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push_i,
    input  wb_entry_t       entry_i,
    input  logic            pop_i,
    output wb_entry_t       head_o,
    output logic [CntW-1:0] count_o,
    output logic            full_o,
    output logic            empty_o
);

    wb_entry_t       mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            do_push, do_pop;

    always_comb begin
        full_o  = (count_q == CntW'(DEPTH));
        empty_o = (count_q == '0);
        do_pop  = pop_i && !empty_o;
        // A pop in the same edge frees the slot, so a full FIFO may still accept.
        do_push = push_i && (!full_o || do_pop);

        // DEPTH is a power of two, so pointers wrap naturally.
        wr_ptr_d = do_push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;

        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        head_o  = mem_q[rd_ptr_q];
        count_o = count_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= entry_i;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-side front end of the 32x32 register file. Merges pipeline writeback (A, no
// backpressure, highest priority) with buffered long-latency results (B) onto the single
// write port, and keeps a per-register scoreboard of outstanding long-latency writes.
//   a_valid/a_addr/a_data : pipeline writeback
//   b_valid/b_ready/b_addr/b_data : long-latency result handshake
//   iss_valid/iss_addr    : long-latency op issue, marks destination pending
//   wr/addr3/data3        : registered register-file write port
//   pending               : scoreboard, bit r set while a B write to r is outstanding
//   a_hold                : asks the pipeline for a writeback bubble after prolonged starvation
//   waw_err               : sticky protocol error flag
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                a_valid,
    input  logic [4:0]          a_addr,
    input  logic [DATA_W-1:0]   a_data,
    input  logic                b_valid,
    output logic                b_ready,
    input  logic [4:0]          b_addr,
    input  logic [DATA_W-1:0]   b_data,
    input  logic                iss_valid,
    input  logic [4:0]          iss_addr,
    output logic                wr,
    output logic [4:0]          addr3,
    output logic [DATA_W-1:0]   data3,
    output logic [NUM_REGS-1:0] pending,
    output logic                a_hold,
    output logic                waw_err
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned StW  = $clog2(STARVE_MAX + 1);

    wb_entry_t       head;
    wb_entry_t       push_entry;
    logic [CntW-1:0] count;
    logic            fifo_full, fifo_empty;
    logic            push, pop;
    logic            a_live, iss_live;
    wb_src_e         src;

    logic                wr_q, wr_d;
    logic [4:0]          addr3_q, addr3_d;
    logic [DATA_W-1:0]   data3_q, data3_d;
    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [StW-1:0]      starve_q, starve_d;
    logic                a_hold_q, a_hold_d;
    logic                waw_err_q, waw_err_d;

    rf_wb_arbiter_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .entry_i (push_entry),
        .pop_i   (pop),
        .head_o  (head),
        .count_o (count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        a_live   = a_valid && (a_addr != REG_ZERO);
        iss_live = iss_valid && (iss_addr != REG_ZERO);

        b_ready    = (count < CntW'(DEPTH));
        // Results for r0 are acknowledged but never buffered.
        push       = b_valid && b_ready && (b_addr != REG_ZERO);
        push_entry = '{addr: b_addr, data: b_data};

        if (a_live) begin
            src = SRC_A;
        end else if (!fifo_empty) begin
            src = SRC_B;
        end else begin
            src = SRC_NONE;
        end
        pop = (src == SRC_B);

        wr_d    = 1'b0;
        addr3_d = addr3_q;
        data3_d = data3_q;
        unique case (src)
            SRC_A: begin
                wr_d    = 1'b1;
                addr3_d = a_addr;
                data3_d = a_data;
            end
            SRC_B: begin
                wr_d    = 1'b1;
                addr3_d = head.addr;
                data3_d = head.data;
            end
            default: wr_d = 1'b0;
        endcase

        // Clear first so a same-edge issue to the retiring register keeps it pending.
        pending_d = pending_q;
        if (pop) begin
            pending_d[head.addr] = 1'b0;
        end
        if (iss_live) begin
            pending_d[iss_addr] = 1'b1;
        end
        pending_d[0] = 1'b0;

        // An issue to a register whose outstanding write retires this very edge is not a
        // hazard: the old value lands now and the new op owns the register afterwards.
        waw_err_d = waw_err_q
            || (iss_live && pending_q[iss_addr] && !(pop && (head.addr == iss_addr)))
            || (a_live && pending_q[a_addr])
            || (pop && !pending_q[head.addr]);

        // Counts only edges where a waiting head lost to A; saturates at the threshold.
        if ((src == SRC_A) && !fifo_empty) begin
            starve_d = (starve_q >= StW'(STARVE_MAX)) ? starve_q : starve_q + StW'(1);
        end else begin
            starve_d = '0;
        end
        a_hold_d = (starve_d >= StW'(STARVE_MAX));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q      <= 1'b0;
            addr3_q   <= '0;
            data3_q   <= '0;
            pending_q <= '0;
            starve_q  <= '0;
            a_hold_q  <= 1'b0;
            waw_err_q <= 1'b0;
        end else begin
            wr_q      <= wr_d;
            addr3_q   <= addr3_d;
            data3_q   <= data3_d;
            pending_q <= pending_d;
            starve_q  <= starve_d;
            a_hold_q  <= a_hold_d;
            waw_err_q <= waw_err_d;
        end
    end

    assign wr      = wr_q;
    assign addr3   = addr3_q;
    assign data3   = data3_q;
    assign pending = pending_q;
    assign a_hold  = a_hold_q;
    assign waw_err = waw_err_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;
    import rf_wb_arbiter_pkg::*;

    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        a_valid = 1'b0;
    logic [4:0]  a_addr = '0;
    logic [31:0] a_data = '0;
    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [4:0]  b_addr = '0;
    logic [31:0] b_data = '0;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_addr = '0;
    logic        wr;
    logic [4:0]  addr3;
    logic [31:0] data3;
    logic [31:0] pending;
    logic        a_hold;
    logic        waw_err;

    int tests = 0;
    int fails = 0;

    // Reference model state
    wb_entry_t   m_q[$];
    bit [31:0]   m_pend;
    bit          m_wr, m_err, m_hold;
    bit [4:0]    m_a3;
    bit [31:0]   m_d3;
    int          m_starve;

    rf_wb_arbiter #(
        .DEPTH      (DEPTH),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .a_valid   (a_valid),
        .a_addr    (a_addr),
        .a_data    (a_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .wr        (wr),
        .addr3     (addr3),
        .data3     (data3),
        .pending   (pending),
        .a_hold    (a_hold),
        .waw_err   (waw_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        reset = 1'b0; a_valid = 1'b0; a_addr = '0; a_data = '0;
        b_valid = 1'b0; b_addr = '0; b_data = '0; iss_valid = 1'b0; iss_addr = '0;
    endtask

    // Advance one edge: update the model from the current inputs, then compare after the edge.
    task automatic step();
        bit        popped;
        bit [4:0]  clr;
        bit [31:0] pold;
        bit        ready;
        wb_entry_t e;
        ready = (m_q.size() < DEPTH);
        chk("b_ready", b_ready, ready);
        if (reset) begin
            m_q.delete(); m_pend = 0; m_wr = 0; m_a3 = 0; m_d3 = 0;
            m_err = 0; m_starve = 0; m_hold = 0;
        end else begin
            popped = 0; clr = 0; pold = m_pend;
            if (a_valid && a_addr != 0) begin
                m_wr = 1; m_a3 = a_addr; m_d3 = a_data;
                if (pold[a_addr]) m_err = 1;
                if (m_q.size() > 0) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : m_starve;
                else m_starve = 0;
            end else if (m_q.size() > 0) begin
                e = m_q.pop_front();
                m_wr = 1; m_a3 = e.addr; m_d3 = e.data;
                if (!pold[e.addr]) m_err = 1;
                popped = 1; clr = e.addr; m_starve = 0;
                m_pend[e.addr] = 0;
            end else begin
                m_wr = 0; m_starve = 0;
            end
            if (iss_valid && iss_addr != 0) begin
                if (pold[iss_addr] && !(popped && clr == iss_addr)) m_err = 1;
                m_pend[iss_addr] = 1;
            end
            if (b_valid && ready && b_addr != 0) m_q.push_back('{addr: b_addr, data: b_data});
            m_hold = (m_starve >= STARVE_MAX);
        end
        @(posedge clk);
        #1;
        chk("wr", wr, m_wr);
        chk("addr3", addr3, m_a3);
        chk("data3", data3, m_d3);
        chk("pending", pending, m_pend);
        chk("a_hold", a_hold, m_hold);
        chk("waw_err", waw_err, m_err);
    endtask

    initial begin
        // Reset
        idle(); reset = 1'b1;
        step(); step();
        chk("rst_wr", wr, 0);
        chk("rst_pending", pending, 0);
        idle();

        // Single pipeline write, 1-cycle latency
        a_valid = 1; a_addr = 5; a_data = 32'h1234;
        step();
        chk("a_wr", wr, 1); chk("a_addr3", addr3, 5); chk("a_data3", data3, 32'h1234);
        idle(); step();
        chk("a_wr_off", wr, 0); chk("a_err", waw_err, 0);

        // Issue then B result: written 2 cycles after acceptance
        iss_valid = 1; iss_addr = 8; step(); idle();
        chk("iss8_pend", pending[8], 1);
        b_valid = 1; b_addr = 8; b_data = 32'hDEADBEEF; step(); idle();
        chk("b8_not_yet", wr, 0);
        step();
        chk("b8_wr", wr, 1); chk("b8_addr3", addr3, 8); chk("b8_data3", data3, 32'hDEADBEEF);
        chk("b8_clear", pending[8], 0);

        // Fill FIFO while A starves it, then drain in order
        for (int r = 9; r <= 12; r++) begin
            iss_valid = 1; iss_addr = 5'(r); step();
        end
        idle();
        for (int i = 0; i < 12; i++) begin
            a_valid = 1; a_addr = 20; a_data = 32'(i);
            if (i < 4) begin
                b_valid = 1; b_addr = 5'(9 + i); b_data = 32'hB000_0000 + 32'(i);
            end else begin
                b_valid = 0;
            end
            step();
        end
        idle();
        chk("full_ready", b_ready, 0);
        chk("starve_hold", a_hold, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("drain_addr", addr3, 9 + i);
            chk("drain_wr", wr, 1);
        end
        chk("drain_ready", b_ready, 1);
        chk("drain_pend", pending, 0);

        // Same-edge set/clear on r3
        iss_valid = 1; iss_addr = 3; step(); idle();
        b_valid = 1; b_addr = 3; b_data = 32'h33; step(); idle();
        iss_valid = 1; iss_addr = 3; step(); idle();
        chk("setclr_pend", pending[3], 1);
        chk("setclr_err", waw_err, 0);

        // Live A to pending r7 sets sticky error
        iss_valid = 1; iss_addr = 7; step(); idle();
        a_valid = 1; a_addr = 7; a_data = 32'h77; step(); idle();
        chk("waw_wr", wr, 1); chk("waw_set", waw_err, 1);
        step();
        chk("waw_sticky", waw_err, 1);

        // Reset with two buffered entries drops them
        iss_valid = 1; iss_addr = 13; step();
        iss_addr = 14; step(); idle();
        a_valid = 1; a_addr = 20; b_valid = 1; b_addr = 13; b_data = 32'h13; step();
        b_addr = 14; b_data = 32'h14; step(); idle();
        reset = 1; step(); idle();
        chk("rst_mid_wr", wr, 0); chk("rst_mid_err", waw_err, 0);
        chk("rst_mid_d3", data3, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("dropped_wr", wr, 0);
        end

        // A no-op on r0 yields the slot to the FIFO head
        iss_valid = 1; iss_addr = 2; step(); idle();
        a_valid = 1; a_addr = 21; b_valid = 1; b_addr = 2; b_data = 32'h22; step(); idle();
        a_valid = 1; a_addr = 0; a_data = 32'hFFFF; step(); idle();
        chk("noop_wr", wr, 1); chk("noop_addr3", addr3, 2); chk("noop_data3", data3, 32'h22);
        a_valid = 1; a_addr = 0; step(); idle();
        chk("noop_nowr", wr, 0);

        // Randomized traffic against the model
        reset = 1; step(); idle();
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 299) == 0);
            a_valid   = a_hold ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
            a_addr    = 5'($urandom_range(0, 31));
            a_data    = $urandom;
            b_valid   = ($urandom_range(0, 2) == 0);
            b_addr    = 5'($urandom_range(0, 31));
            b_data    = $urandom;
            iss_valid = ($urandom_range(0, 3) == 0);
            iss_addr  = 5'($urandom_range(0, 31));
            step();
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
